// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and default sizes for the 2x2 max-pool window
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    localparam int DATA_W_DEF   = 9;
    localparam int MAX_COLS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pool_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : pool_line_buf
// Description : One-row pixel store, single write port, two async read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int AW       = $clog2(MAX_COLS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr0_i,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);

    // No reset: every entry is written on an even row before an odd row reads it.
    logic [DATA_W-1:0] mem_q [MAX_COLS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule
`default_nettype wire

// File: rtl/pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pool_ctrl
// Description : Gathers a raster pixel stream into 2x2 windows for max-pool.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int CNT_W    = $clog2(MAX_COLS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_cols,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              win_valid,
    output logic [DATA_W-1:0] win_a00,
    output logic [DATA_W-1:0] win_a01,
    output logic [DATA_W-1:0] win_a10,
    output logic [DATA_W-1:0] win_a11,
    input  logic              win_ready,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(MAX_COLS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cols_q, cols_d, rows_q, rows_d;
    logic [CNT_W-1:0]    col_q, col_d, row_q, row_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic [DATA_W-1:0]   a00_q, a00_d, a01_q, a01_d, a10_q, a10_d, a11_q, a11_d;
    logic                win_valid_q, win_valid_d;

    logic                w_accept;
    logic                w_last_col;
    logic                w_last_pix;
    logic                w_pool_load;
    logic                w_buf_we;
    logic                w_cfg_ok;
    logic [AW-1:0]       w_col_lo;
    logic [AW-1:0]       w_col_lo_m1;
    logic [DATA_W-1:0]   w_rd0, w_rd1;

    assign in_ready    = (state_q == ST_RUN) && !(win_valid_q && !win_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_last_col  = (col_q == cols_q - CNT_W'(1));
    assign w_last_pix  = w_last_col && (row_q == rows_q - CNT_W'(1));
    // Odd row, odd column closes a 2x2 block; trailing odd column/row never does.
    assign w_pool_load = w_accept && row_q[0] && col_q[0];
    assign w_buf_we    = w_accept && !row_q[0];
    assign w_cfg_ok    = (cfg_cols >= CNT_W'(2)) && (cfg_rows >= CNT_W'(2)) &&
                         (cfg_cols <= CNT_W'(MAX_COLS));
    assign w_col_lo    = col_q[AW-1:0];
    assign w_col_lo_m1 = w_col_lo - AW'(1);

    pool_line_buf #(
        .DATA_W   (DATA_W),
        .MAX_COLS (MAX_COLS),
        .AW       (AW)
    ) u_line_buf (
        .clk      (clk),
        .we_i     (w_buf_we),
        .waddr_i  (w_col_lo),
        .wdata_i  (in_data),
        .raddr0_i (w_col_lo_m1),
        .raddr1_i (w_col_lo),
        .rdata0_o (w_rd0),
        .rdata1_o (w_rd1)
    );

    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        col_d       = col_q;
        row_d       = row_q;
        left_d      = left_q;
        a00_d       = a00_q;
        a01_d       = a01_q;
        a10_d       = a10_q;
        a11_d       = a11_q;
        win_valid_d = win_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && w_cfg_ok) begin
                    state_d = ST_RUN;
                    cols_d  = cfg_cols;
                    rows_d  = cfg_rows;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_last_col) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1);
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                    if (w_last_pix) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!win_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (w_accept && row_q[0] && !col_q[0]) begin
            left_d = in_data;
        end

        // A new window may replace one being handed off in the same cycle.
        if (w_pool_load) begin
            a00_d       = w_rd0;
            a01_d       = w_rd1;
            a10_d       = left_q;
            a11_d       = in_data;
            win_valid_d = 1'b1;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            left_q      <= '0;
            a00_q       <= '0;
            a01_q       <= '0;
            a10_q       <= '0;
            a11_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            col_q       <= col_d;
            row_q       <= row_d;
            left_q      <= left_d;
            a00_q       <= a00_d;
            a01_q       <= a01_d;
            a10_q       <= a10_d;
            a11_q       <= a11_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_a00   = a00_q;
    assign win_a01   = a01_q;
    assign win_a10   = a10_q;
    assign win_a11   = a11_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter DATA_W, default 9: signed pixel width.
REQ-002 Parameter MAX_COLS, default 64: maximum frame width in pixels; CNT_W = clog2(MAX_COLS)+1.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle frame request; honoured only in IDLE.
REQ-006 cfg_cols, cfg_rows  in  CNT_W each  frame size; latched at accepted start.
REQ-007 in_valid, in_data  in  1, DATA_W  raster-order pixel stream; in_data signed.
REQ-008 in_ready  out  1  pixel accepted when in_valid && in_ready.
REQ-009 win_valid  out  1  2x2 window available.
REQ-010 win_a00, win_a01, win_a10, win_a11  out  DATA_W each  window: top-left, top-right, bottom-left, bottom-right.
REQ-011 win_ready  in  1  max-pool datapath consumes window when win_valid && win_ready.
REQ-012 busy, done  out  1 each  busy=state!=IDLE; done = one-cycle pulse at end of frame.

Function
REQ-013 States: IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on acceptance of last pixel (row=rows-1, col=cols-1); FLUSH->DONE when win_valid=0; DONE->IDLE unconditionally next cycle.
REQ-014 start in any state other than IDLE is ignored; cfg changes after latch have no effect.
REQ-015 cfg_cols or cfg_rows <2, or cfg_cols >MAX_COLS: start ignored, stays IDLE.
REQ-016 col/row counters advance per accepted pixel; col wraps to 0 at cols-1 and row increments.
REQ-017 Even rows (row[0]=0): accepted pixel written to line buffer at address col.
REQ-018 Odd rows, even col: pixel held in left-pixel register.
REQ-019 Odd rows, odd col: window registered next edge: a00=linebuf[col-1], a01=linebuf[col], a10=left register, a11=current pixel; win_valid set; latency 1 cycle from accepting pixel.
REQ-020 Odd cfg_cols/cfg_rows: trailing column/row pixels accepted, never pooled (floor semantics).
REQ-021 Window outputs and win_valid held stable until win_ready; win_valid cleared on handshake unless a new window loads same cycle.
REQ-022 in_ready = (state==RUN) && !(win_valid && !win_ready); simultaneous handshake and new window load permitted, no bubble.
REQ-023 done=1 exactly one cycle, in DONE state; in_ready=0 outside RUN.
REQ-024 No arithmetic on pixel data; values passed bit-exact, sign preserved.

Reset
REQ-025 rst asserted: state=IDLE, counters=0, win_valid=0, window regs=0, in_ready=0, done=0, busy=0, asynchronously.
REQ-026 Reset mid-frame aborts frame; no done pulse; line buffer contents need not be cleared (never read before rewritten).

Structure
REQ-027 Shared package pool_pkg: state enum, DATA_W default, MAX_COLS default.
REQ-028 One sub-module: pool_line_buf (MAX_COLS x DATA_W, one write port, two async read ports at col-1 and col).
REQ-029 Target size 120-400 RTL lines total.

Verification
REQ-030 4x4 frame, pixels 0..15, win_ready=1 -> windows (0,1,4,5),(2,3,6,7),(8,9,12,13),(10,11,14,15), done one cycle after FLUSH exits.
REQ-031 Same frame, win_ready low 3 cycles after first window -> in_ready=0 for those cycles, window (0,1,4,5) stable, no pixel lost.
REQ-032 cfg 5x3, pixels 0..14 -> exactly windows (0,1,5,6),(2,3,7,8); pixels 4,9,10..14 dropped; done asserted.
REQ-033 Signed pixels -256,255,-1,0 in 2x2 frame -> window (-256,255,-1,0) bit-exact.
REQ-034 rst asserted after 6 pixels of 4x4 frame -> all outputs 0 immediately, no done; new start runs full 4x4 correctly.
REQ-035 start pulsed during RUN and cfg_cols=1 start in IDLE -> both ignored, busy unaffected.
